// File: rtl/mem_ws_if.sv
// mem_ws_if -- request/response bundle for the mem_ws wait-state memory.
//   slave  modport : the memory (mem_ws) side
//   master modport : the requester side
// Signals:
//   add_r/add_w  byte read / write addresses
//   data_w, be   write data and per-byte write enables
//   rd, wr       access requests
//   data_r       registered read data, rvalid marks it valid (one cycle)
//   req          busy; requests are ignored while high
//   err_align/err_limit  sticky error flags, err_clr clears them
//   stop_active  one-cycle pulse on any error detection
interface mem_ws_if #(
  parameter int DATA_W = 32
);
  logic [31:0]         add_r;
  logic [31:0]         add_w;
  logic [DATA_W-1:0]   data_w;
  logic [DATA_W/8-1:0] be;
  logic                rd;
  logic                wr;
  logic [DATA_W-1:0]   data_r;
  logic                rvalid;
  logic                req;
  logic                err_align;
  logic                err_limit;
  logic                err_clr;
  logic                stop_active;

  modport slave (
    input  add_r, add_w, data_w, be, rd, wr, err_clr,
    output data_r, rvalid, req, err_align, err_limit, stop_active
  );

  modport master (
    output add_r, add_w, data_w, be, rd, wr, err_clr,
    input  data_r, rvalid, req, err_align, err_limit, stop_active
  );
endinterface

// File: rtl/mem_ws.sv
// mem_ws -- byte-enabled word memory with a configurable number of wait
// states, alignment/limit checking and sticky error flags.
// Ports:
//   clk  single clock, all state on the rising edge
//   rst  asynchronous active-high reset (storage contents are kept)
//   bus  mem_ws_if.slave: addresses, write data/enables, rd/wr requests,
//        registered read data + rvalid, req busy, error flags and pulse
// Timing: WAIT=0 performs the access at the request edge. WAIT>0 captures
// the request, holds req high for WAIT cycles (BUSY then DONE) and performs
// the access at the edge that leaves DONE.
module mem_ws #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int ADR_LIMIT = 64,
  parameter int WAIT      = 0
) (
  input  logic      clk,
  input  logic      rst,
  mem_ws_if.slave   bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] OFF_MASK = 32'(NB - 1);
  localparam logic [31:0] LIMIT    = 32'(ADR_LIMIT);
  // Last BUSY count value before moving on to DONE.
  localparam logic [3:0]  WAIT_LAST = (WAIT > 1) ? 4'(WAIT - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_reg, state_next;

  logic [3:0]        wait_cnt_reg;
  logic [31:0]       cap_add_r_reg, cap_add_w_reg;
  logic [DATA_W-1:0] cap_data_reg;
  logic [NB-1:0]     cap_be_reg;
  logic              cap_rd_reg, cap_wr_reg;

  logic [DATA_W-1:0] data_r_reg;
  logic              rvalid_reg;
  logic              stop_reg;
  logic              err_align_reg;
  logic              err_limit_reg;
  logic              req_out;

  // Request acceptance and error detection happen on the raw inputs.
  logic accept;
  logic det_align, det_limit;

  // Access stage: either the live inputs (WAIT=0) or the captured request.
  logic              acc_go, acc_rd, acc_wr;
  logic [31:0]       acc_add_r, acc_add_w;
  logic [DATA_W-1:0] acc_data;
  logic [NB-1:0]     acc_be;
  logic [31:0]       acc_word_r, acc_word_w;
  logic              acc_lim_r, acc_lim_w;
  logic              acc_rd_en, acc_wr_en;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [DATA_W-1:0] mem_rdata;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a >> OFF_W;
  endfunction

  function automatic logic misaligned(input logic [31:0] a);
    return (a & OFF_MASK) != 32'd0;
  endfunction

  function automatic logic over_limit(input logic [31:0] a);
    return word_of(a) >= LIMIT;
  endfunction

  assign accept    = (state_reg == IDLE) && (bus.rd || bus.wr);
  assign det_align = accept && ((bus.rd && misaligned(bus.add_r)) ||
                                (bus.wr && misaligned(bus.add_w)));
  assign det_limit = accept && ((bus.rd && over_limit(bus.add_r)) ||
                                (bus.wr && over_limit(bus.add_w)));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // With a single wait state the only busy cycle is DONE itself.
        if (accept && (WAIT > 0)) begin
          state_next = (WAIT == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_out = (state_reg != IDLE);
  end

  // ---------------- access stage select ----------------
  always_comb begin
    acc_go    = 1'b0;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    acc_add_r = '0;
    acc_add_w = '0;
    acc_data  = '0;
    acc_be    = '0;
    if (WAIT == 0) begin
      acc_go    = accept;
      acc_rd    = bus.rd;
      acc_wr    = bus.wr;
      acc_add_r = bus.add_r;
      acc_add_w = bus.add_w;
      acc_data  = bus.data_w;
      acc_be    = bus.be;
    end else begin
      acc_go    = (state_reg == DONE);
      acc_rd    = cap_rd_reg;
      acc_wr    = cap_wr_reg;
      acc_add_r = cap_add_r_reg;
      acc_add_w = cap_add_w_reg;
      acc_data  = cap_data_reg;
      acc_be    = cap_be_reg;
    end
  end

  assign acc_word_r = word_of(acc_add_r);
  assign acc_word_w = word_of(acc_add_w);
  assign acc_lim_r  = acc_word_r >= LIMIT;
  assign acc_lim_w  = acc_word_w >= LIMIT;
  assign rd_idx     = acc_word_r[IDX_W-1:0];
  assign wr_idx     = acc_word_w[IDX_W-1:0];
  assign acc_rd_en  = acc_go && acc_rd;
  // Reset is level-sensitive here so a clock edge seen while rst is held
  // can never sneak a write into storage.
  assign acc_wr_en  = acc_go && acc_wr && !acc_lim_w && !rst;

  // ---------------- storage: one array per byte lane ----------------
  // Split lanes keep each array single-writer and map onto byte-wide RAM.
  // Storage has no reset; contents survive rst.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (acc_wr_en && acc_be[gi]) begin
          mem[wr_idx] <= acc_data[8*gi +: 8];
        end
      end

      // Combined read of the old value; the read register below samples
      // it on the same edge as any write, giving read-before-write.
      assign mem_rdata[8*gi +: 8] = mem[rd_idx];
    end
  endgenerate

  // ---------------- datapath / flags ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r_reg    <= '0;
      rvalid_reg    <= 1'b0;
      stop_reg      <= 1'b0;
      err_align_reg <= 1'b0;
      err_limit_reg <= 1'b0;
      wait_cnt_reg  <= '0;
      cap_add_r_reg <= '0;
      cap_add_w_reg <= '0;
      cap_data_reg  <= '0;
      cap_be_reg    <= '0;
      cap_rd_reg    <= 1'b0;
      cap_wr_reg    <= 1'b0;
    end else begin
      rvalid_reg <= acc_rd_en;
      if (acc_rd_en) begin
        data_r_reg <= acc_lim_r ? '0 : mem_rdata;
      end

      stop_reg <= det_align || det_limit;
      if (bus.err_clr) begin
        err_align_reg <= 1'b0;
        err_limit_reg <= 1'b0;
      end else begin
        if (det_align) err_align_reg <= 1'b1;
        if (det_limit) err_limit_reg <= 1'b1;
      end

      if (accept) begin
        cap_add_r_reg <= bus.add_r;
        cap_add_w_reg <= bus.add_w;
        cap_data_reg  <= bus.data_w;
        cap_be_reg    <= bus.be;
        cap_rd_reg    <= bus.rd;
        cap_wr_reg    <= bus.wr;
      end

      if (state_reg == BUSY) begin
        wait_cnt_reg <= wait_cnt_reg + 4'd1;
      end else begin
        wait_cnt_reg <= '0;
      end
    end
  end

  assign bus.data_r      = data_r_reg;
  assign bus.rvalid      = rvalid_reg;
  assign bus.req         = req_out;
  assign bus.err_align   = err_align_reg;
  assign bus.err_limit   = err_limit_reg;
  assign bus.stop_active = stop_reg;

endmodule

// File: tb/tb_mem_ws.sv
// tb_mem_ws -- directed bench for mem_ws: a WAIT=0 instance driven from a
// vector table and a WAIT=3 instance exercised with hand-written sequences
// (wait-state timing, ignored requests, error pulse timing, reset abort).
module tb_mem_ws;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mem_ws_if #(.DATA_W(32)) b0 ();
  mem_ws_if #(.DATA_W(32)) b3 ();

  mem_ws #(.DATA_W(32), .DEPTH(64), .ADR_LIMIT(64), .WAIT(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );
  mem_ws #(.DATA_W(32), .DEPTH(64), .ADR_LIMIT(64), .WAIT(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd, wr, clr;
    logic [31:0] ar, aw, dw;
    logic [3:0]  be;
    logic        ev;
    logic [31:0] ed;
    logic        ea, el, es;
  } vec_t;

  function automatic vec_t mk(input logic rd, wr, clr, input logic [31:0] ar, aw, dw,
                              input logic [3:0] be, input logic ev, input logic [31:0] ed,
                              input logic ea, el, es);
    vec_t v;
    v.rd = rd; v.wr = wr; v.clr = clr; v.ar = ar; v.aw = aw; v.dw = dw; v.be = be;
    v.ev = ev; v.ed = ed; v.ea = ea; v.el = el; v.es = es;
    return v;
  endfunction

  localparam int NV = 23;
  vec_t vt [NV];

  // Results of one WAIT=3 transaction, filled by run3.
  int          r_req, r_rv, r_rvat, r_stop, r_stopat;
  logic [31:0] r_rvdata;

  task automatic clear3();
    b3.rd = 0; b3.wr = 0; b3.add_r = 0; b3.add_w = 0;
    b3.data_w = 0; b3.be = 0; b3.err_clr = 0;
  endtask

  task automatic sample3(input int k);
    if (b3.req) r_req++;
    if (b3.rvalid) begin
      r_rv++; r_rvat = k; r_rvdata = b3.data_r;
    end
    if (b3.stop_active) begin
      r_stop++; r_stopat = k;
    end
  endtask

  // One WAIT=3 transaction; optional junk read held during the busy window.
  task automatic run3(input logic rd, wr, input logic [31:0] ar, aw, dw,
                      input logic [3:0] be, input logic junk);
    r_req = 0; r_rv = 0; r_rvat = -1; r_stop = 0; r_stopat = -1; r_rvdata = 0;
    @(negedge clk);
    b3.rd = rd; b3.wr = wr; b3.add_r = ar; b3.add_w = aw; b3.data_w = dw; b3.be = be;
    @(posedge clk); #1; sample3(0);
    @(negedge clk);
    clear3();
    if (junk) begin
      b3.rd = 1; b3.add_r = 32'h14;
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1; sample3(k);
      @(negedge clk);
      if (k >= 3) clear3();
    end
    $display("W3 rd=%0b wr=%0b ar=0x%08h aw=0x%08h dw=0x%08h be=%h junk=%0b : req_cycles=%0d rvalid_cnt=%0d rvalid_at=%0d data_r=0x%08h stop_at=%0d",
             rd, wr, ar, aw, dw, be, junk, r_req, r_rv, r_rvat, r_rvdata, r_stopat);
  endtask

  task automatic chk_zero3(input string tag);
    chk({tag, ".req"},       32'(b3.req), 0);
    chk({tag, ".rvalid"},    32'(b3.rvalid), 0);
    chk({tag, ".data_r"},    b3.data_r, 0);
    chk({tag, ".err_align"}, 32'(b3.err_align), 0);
    chk({tag, ".err_limit"}, 32'(b3.err_limit), 0);
    chk({tag, ".stop"},      32'(b3.stop_active), 0);
  endtask

  initial begin
    vt[0]  = mk(0,1,0, 32'h0,   32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0,        0,0,0);
    vt[1]  = mk(1,0,0, 32'h10,  32'h0,   32'h0,        4'h0, 1, 32'hDEADBEEF, 0,0,0);
    vt[2]  = mk(0,0,0, 32'h0,   32'h0,   32'h0,        4'h0, 0, 32'hDEADBEEF, 0,0,0);
    vt[3]  = mk(0,1,0, 32'h0,   32'h10,  32'h11223344, 4'h5, 0, 32'hDEADBEEF, 0,0,0);
    vt[4]  = mk(1,0,0, 32'h10,  32'h0,   32'h0,        4'h0, 1, 32'hDE22BE44, 0,0,0);
    vt[5]  = mk(0,1,0, 32'h0,   32'h20,  32'h1,        4'hF, 0, 32'hDE22BE44, 0,0,0);
    vt[6]  = mk(1,1,0, 32'h20,  32'h20,  32'h2,        4'hF, 1, 32'h1,        0,0,0);
    vt[7]  = mk(1,0,0, 32'h20,  32'h0,   32'h0,        4'h0, 1, 32'h2,        0,0,0);
    vt[8]  = mk(0,1,0, 32'h0,   32'h20,  32'hFFFFFFFF, 4'h0, 0, 32'h2,        0,0,0);
    vt[9]  = mk(1,0,0, 32'h20,  32'h0,   32'h0,        4'h0, 1, 32'h2,        0,0,0);
    vt[10] = mk(0,1,0, 32'h0,   32'h0,   32'h55AA55AA, 4'hF, 0, 32'h2,        0,0,0);
    vt[11] = mk(1,0,0, 32'h13,  32'h0,   32'h0,        4'h0, 1, 32'hDE22BE44, 1,0,1);
    vt[12] = mk(0,0,0, 32'h0,   32'h0,   32'h0,        4'h0, 0, 32'hDE22BE44, 1,0,0);
    vt[13] = mk(0,1,0, 32'h0,   32'h100, 32'hCAFEF00D, 4'hF, 0, 32'hDE22BE44, 1,1,1);
    vt[14] = mk(1,0,0, 32'h100, 32'h0,   32'h0,        4'h0, 1, 32'h0,        1,1,1);
    vt[15] = mk(1,0,0, 32'h0,   32'h0,   32'h0,        4'h0, 1, 32'h55AA55AA, 1,1,0);
    vt[16] = mk(0,0,1, 32'h0,   32'h0,   32'h0,        4'h0, 0, 32'h55AA55AA, 0,0,0);
    vt[17] = mk(1,0,1, 32'h13,  32'h0,   32'h0,        4'h0, 1, 32'hDE22BE44, 0,0,1);
    vt[18] = mk(0,0,0, 32'h0,   32'h0,   32'h0,        4'h0, 0, 32'hDE22BE44, 0,0,0);
    vt[19] = mk(0,1,0, 32'h0,   32'h22,  32'h000000AB, 4'h1, 0, 32'hDE22BE44, 1,0,1);
    vt[20] = mk(1,0,0, 32'h20,  32'h0,   32'h0,        4'h0, 1, 32'h000000AB, 1,0,0);
    vt[21] = mk(0,1,0, 32'h0,   32'hFC,  32'h0F0F0F0F, 4'hF, 0, 32'h000000AB, 1,0,0);
    vt[22] = mk(1,0,0, 32'hFC,  32'h0,   32'h0,        4'h0, 1, 32'h0F0F0F0F, 1,0,0);

    b0.rd = 0; b0.wr = 0; b0.add_r = 0; b0.add_w = 0;
    b0.data_w = 0; b0.be = 0; b0.err_clr = 0;
    clear3();

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst0.data_r", b0.data_r, 0);
    chk("rst0.rvalid", 32'(b0.rvalid), 0);
    chk("rst0.req",    32'(b0.req), 0);
    chk("rst0.flags",  {30'd0, b0.err_align, b0.err_limit}, 0);
    chk("rst0.stop",   32'(b0.stop_active), 0);
    chk_zero3("rst3");

    // ---------------- WAIT=0 table ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      b0.rd = vt[i].rd; b0.wr = vt[i].wr; b0.err_clr = vt[i].clr;
      b0.add_r = vt[i].ar; b0.add_w = vt[i].aw; b0.data_w = vt[i].dw; b0.be = vt[i].be;
      @(posedge clk); #1;
      $display("W0 vec%0d rd=%0b wr=%0b clr=%0b ar=0x%08h aw=0x%08h dw=0x%08h be=%h : rvalid=%0b data_r=0x%08h align=%0b limit=%0b stop=%0b req=%0b",
               i, vt[i].rd, vt[i].wr, vt[i].clr, vt[i].ar, vt[i].aw, vt[i].dw, vt[i].be,
               b0.rvalid, b0.data_r, b0.err_align, b0.err_limit, b0.stop_active, b0.req);
      chk($sformatf("v%0d.rvalid", i),    32'(b0.rvalid), 32'(vt[i].ev));
      chk($sformatf("v%0d.data_r", i),    b0.data_r, vt[i].ed);
      chk($sformatf("v%0d.err_align", i), 32'(b0.err_align), 32'(vt[i].ea));
      chk($sformatf("v%0d.err_limit", i), 32'(b0.err_limit), 32'(vt[i].el));
      chk($sformatf("v%0d.stop", i),      32'(b0.stop_active), 32'(vt[i].es));
      chk($sformatf("v%0d.req", i),       32'(b0.req), 0);
    end
    @(negedge clk);
    b0.rd = 0; b0.wr = 0; b0.err_clr = 0;

    // ---------------- WAIT=3 sequences ----------------
    run3(0, 1, 32'h0, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    chk("w3wr.req_cycles", 32'(r_req), 3);
    chk("w3wr.rvalid_cnt", 32'(r_rv), 0);
    chk("w3wr.stop_cnt",   32'(r_stop), 0);

    run3(1, 0, 32'h10, 32'h0, 32'h0, 4'h0, 1);
    chk("w3rd.req_cycles", 32'(r_req), 3);
    chk("w3rd.rvalid_cnt", 32'(r_rv), 1);
    chk("w3rd.rvalid_at",  32'(r_rvat), 3);
    chk("w3rd.data_r",     r_rvdata, 32'hDEADBEEF);

    run3(1, 0, 32'h13, 32'h0, 32'h0, 4'h0, 0);
    chk("w3al.stop_cnt",  32'(r_stop), 1);
    chk("w3al.stop_at",   32'(r_stopat), 0);
    chk("w3al.err_align", 32'(b3.err_align), 1);
    chk("w3al.data_r",    r_rvdata, 32'hDEADBEEF);

    run3(0, 1, 32'h0, 32'h100, 32'h12345678, 4'hF, 0);
    chk("w3lim.err_limit", 32'(b3.err_limit), 1);
    chk("w3lim.stop_at",   32'(r_stopat), 0);

    @(negedge clk); b3.err_clr = 1;
    @(posedge clk); #1;
    chk("w3clr.flags", {30'd0, b3.err_align, b3.err_limit}, 0);
    @(negedge clk); b3.err_clr = 0;
    $display("W3 err_clr : align=%0b limit=%0b", b3.err_align, b3.err_limit);

    // Reset while a write is pending in BUSY.
    run3(1, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0);  // refresh data_r (aliased word 0)
    @(negedge clk);
    b3.wr = 1; b3.add_w = 32'h10; b3.data_w = 32'h0BADF00D; b3.be = 4'hF;
    @(posedge clk); #1;
    chk("w3abort.req_after_capture", 32'(b3.req), 1);
    @(negedge clk); clear3();
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk_zero3("w3abort.async");
    repeat (3) @(posedge clk);
    #1;
    chk_zero3("w3abort.held");
    @(negedge clk); rst = 0;
    $display("W3 reset during BUSY write : req=%0b data_r=0x%08h", b3.req, b3.data_r);

    run3(1, 0, 32'h10, 32'h0, 32'h0, 4'h0, 0);
    chk("w3post.req_cycles", 32'(r_req), 3);
    chk("w3post.rvalid_cnt", 32'(r_rv), 1);
    chk("w3post.data_r",     r_rvdata, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
